regfile_port_arbiter: RTL and testbench
=======================================

REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 Parameter STACK_DEPTH, default 8: number of return-stack entries in the register file.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 alu_req / alu_ws / alu_wd  input  1/3/32  ALU writeback request, target register, data.
REQ-005 mem_req / mem_ws / mem_wd  input  1/3/32  memory-load writeback request, target register, data.
REQ-006 call_req / call_pc  input  1/8  call unit push request and return address.
REQ-007 ret_req  input  1  return unit pop request.
REQ-008 clr_err  input  1  synchronous clear of sticky error flags.
REQ-009 alu_gnt, mem_gnt, call_gnt, ret_gnt  output  1 each  one-cycle grant pulses.
REQ-010 regwrite / ws / wd  output  1/3/32  register file write port.
REQ-011 push / pop / stack_pc  output  1/1/8  register file stack controls.
REQ-012 stk_depth  output  4  current stack occupancy, 0..STACK_DEPTH.
REQ-013 stk_full, stk_empty  output  1 each  occupancy == STACK_DEPTH, occupancy == 0.
REQ-014 stk_ovf, stk_unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-015 All outputs except stk_full/stk_empty SHALL be registered; requests sampled at edge k produce gnt and register-file controls high during cycle k..k+1 only.
REQ-016 At most one operation (write, push or pop) SHALL be issued per cycle; exactly one gnt high per issued operation.
REQ-017 Fixed priority: ret_req > call_req > {alu_req, mem_req}.
REQ-018 Between alu_req and mem_req, round-robin: when both eligible, grant the one not granted at the previous writeback; after reset ALU wins first tie.
REQ-019 A requester whose gnt is high in the current cycle SHALL be ineligible at the next edge (requester drops req on seeing gnt).
REQ-020 Writeback grant: regwrite=1, ws/wd = granted requester's ws/wd captured at the sampling edge.
REQ-021 Call grant with depth < STACK_DEPTH: push=1, stack_pc=call_pc, depth +1.
REQ-022 Ret grant with depth > 0: pop=1, depth -1.
REQ-023 Call with depth == STACK_DEPTH: call_gnt=1, push=0, depth unchanged, stk_ovf set.
REQ-024 Ret with depth == 0: ret_gnt=1, pop=0, depth unchanged, stk_unf set.
REQ-025 When no operation issued: regwrite=push=pop=0, ws/wd/stack_pc hold previous values.
REQ-026 Lower-priority requests not granted SHALL remain pending (no loss) and be granted in later cycles by REQ-017/018.
REQ-027 clr_err clears stk_ovf/stk_unf at next edge; a same-edge new ovf/unf event wins (flag set).
REQ-028 Depth SHALL never wrap below 0 or above STACK_DEPTH.

Reset
REQ-029 Reset SHALL force all gnt, regwrite, push, pop, ws, wd, stack_pc, stk_depth, stk_ovf, stk_unf to 0 and round-robin pointer to ALU-first, immediately and independent of clk.
REQ-030 Reset asserted mid-operation SHALL drop any issued control in that cycle; pending requests are re-arbitrated after reset release.

Structure
REQ-031 Package regfile_pkg SHALL hold REG_ADDR_W=3, DATA_W=32, PC_W=8, default STACK_DEPTH and the operation-type enumeration (NONE, WB_ALU, WB_MEM, PUSH, POP).
REQ-032 Stack occupancy counter and ovf/unf flags SHALL be one sub-module, stack_depth_tracker; arbitration stays in the top.

Verification
REQ-033 alu_req (ws=2, wd=25) and mem_req (ws=3, wd=7) same edge after reset -> cycle 1 regwrite ws=2 wd=25 alu_gnt; cycle 2 regwrite ws=3 wd=7 mem_gnt.
REQ-034 call_req (call_pc=35) with alu_req pending -> call_gnt, push=1, stack_pc=35, depth 1; next cycle alu write issued.
REQ-035 ret_req at depth 0 -> ret_gnt=1, pop=0, stk_unf=1, depth 0; clr_err next cycle -> stk_unf=0.
REQ-036 9 consecutive calls (STACK_DEPTH=8) -> push on first 8, stk_full=1 after 8th, 9th gnt without push, stk_ovf=1.
REQ-037 alu_req and mem_req held continuously for 6 cycles -> grants alternate ALU, MEM, ALU, ... with no cycle carrying two gnts.
REQ-038 reset pulsed during cycle with push=1 at depth 3 -> push drops immediately, depth 0, all outputs 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, default stack depth and the arbiter operation encoding
// used by the register-file port arbiter and its stack tracker.
package regfile_pkg;

  localparam int REG_ADDR_W      = 3;
  localparam int DATA_W          = 32;
  localparam int PC_W            = 8;
  localparam int STACK_DEPTH_DEF = 8;
  localparam int DEPTH_W         = 4;

  typedef enum logic [2:0] {
    NONE,
    WB_ALU,
    WB_MEM,
    PUSH,
    POP
  } op_e;

endpackage

// File: rtl/stack_depth_tracker.sv
// Return-stack occupancy counter with saturating bounds and sticky
// overflow/underflow flags; one-cycle update, never stalls.
module stack_depth_tracker
  import regfile_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               call_i,
  input  logic               ret_i,
  input  logic               clr_err_i,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               ovf_o,
  output logic               unf_o
);

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               full, empty;

  assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty = (depth_q == '0);

  always_comb begin
    depth_d = depth_q;
    if (call_i && !full) begin
      depth_d = depth_q + 1'b1;
    end else if (ret_i && !empty) begin
      depth_d = depth_q - 1'b1;
    end
    // A fresh error event on the same edge as clr_err keeps the flag set.
    ovf_d = (ovf_q & ~clr_err_i) | (call_i & full);
    unf_d = (unf_q & ~clr_err_i) | (ret_i & empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign depth_o = depth_q;
  assign full_o  = full;
  assign empty_o = empty;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates ALU/memory writebacks and call/return stack ops onto one register-file
// port: fixed priority ret > call > writeback, round-robin between writebacks, registered outputs.
module regfile_port_arbiter
  import regfile_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_req,
  input  logic [REG_ADDR_W-1:0] alu_ws,
  input  logic [DATA_W-1:0]     alu_wd,
  input  logic                  mem_req,
  input  logic [REG_ADDR_W-1:0] mem_ws,
  input  logic [DATA_W-1:0]     mem_wd,
  input  logic                  call_req,
  input  logic [PC_W-1:0]       call_pc,
  input  logic                  ret_req,
  input  logic                  clr_err,
  output logic                  alu_gnt,
  output logic                  mem_gnt,
  output logic                  call_gnt,
  output logic                  ret_gnt,
  output logic                  regwrite,
  output logic [REG_ADDR_W-1:0] ws,
  output logic [DATA_W-1:0]     wd,
  output logic                  push,
  output logic                  pop,
  output logic [PC_W-1:0]       stack_pc,
  output logic [DEPTH_W-1:0]    stk_depth,
  output logic                  stk_full,
  output logic                  stk_empty,
  output logic                  stk_ovf,
  output logic                  stk_unf
);

  op_e                   op_sel;
  logic                  alu_gnt_q, mem_gnt_q, call_gnt_q, ret_gnt_q;
  logic                  alu_gnt_d, mem_gnt_d, call_gnt_d, ret_gnt_d;
  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] ws_q, ws_d;
  logic [DATA_W-1:0]     wd_q, wd_d;
  logic                  push_q, push_d;
  logic                  pop_q, pop_d;
  logic [PC_W-1:0]       stack_pc_q, stack_pc_d;
  logic                  mem_first_q, mem_first_d;
  logic                  alu_elig, mem_elig, call_elig, ret_elig;

  // A requester still showing its grant has not yet dropped its request.
  assign alu_elig  = alu_req  & ~alu_gnt_q;
  assign mem_elig  = mem_req  & ~mem_gnt_q;
  assign call_elig = call_req & ~call_gnt_q;
  assign ret_elig  = ret_req  & ~ret_gnt_q;

  always_comb begin
    op_sel = NONE;
    if (ret_elig) begin
      op_sel = POP;
    end else if (call_elig) begin
      op_sel = PUSH;
    end else if (alu_elig && mem_elig) begin
      op_sel = mem_first_q ? WB_MEM : WB_ALU;
    end else if (alu_elig) begin
      op_sel = WB_ALU;
    end else if (mem_elig) begin
      op_sel = WB_MEM;
    end
  end

  always_comb begin
    alu_gnt_d   = (op_sel == WB_ALU);
    mem_gnt_d   = (op_sel == WB_MEM);
    call_gnt_d  = (op_sel == PUSH);
    ret_gnt_d   = (op_sel == POP);
    regwrite_d  = alu_gnt_d | mem_gnt_d;
    ws_d        = ws_q;
    wd_d        = wd_q;
    mem_first_d = mem_first_q;
    if (alu_gnt_d) begin
      ws_d        = alu_ws;
      wd_d        = alu_wd;
      mem_first_d = 1'b1;
    end else if (mem_gnt_d) begin
      ws_d        = mem_ws;
      wd_d        = mem_wd;
      mem_first_d = 1'b0;
    end
    // Calls at full depth and returns at empty depth are granted but not issued.
    push_d     = call_gnt_d & ~stk_full;
    pop_d      = ret_gnt_d & ~stk_empty;
    stack_pc_d = push_d ? call_pc : stack_pc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_gnt_q   <= 1'b0;
      mem_gnt_q   <= 1'b0;
      call_gnt_q  <= 1'b0;
      ret_gnt_q   <= 1'b0;
      regwrite_q  <= 1'b0;
      ws_q        <= '0;
      wd_q        <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      stack_pc_q  <= '0;
      mem_first_q <= 1'b0;
    end else begin
      alu_gnt_q   <= alu_gnt_d;
      mem_gnt_q   <= mem_gnt_d;
      call_gnt_q  <= call_gnt_d;
      ret_gnt_q   <= ret_gnt_d;
      regwrite_q  <= regwrite_d;
      ws_q        <= ws_d;
      wd_q        <= wd_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      stack_pc_q  <= stack_pc_d;
      mem_first_q <= mem_first_d;
    end
  end

  stack_depth_tracker #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .call_i   (call_gnt_d),
    .ret_i    (ret_gnt_d),
    .clr_err_i(clr_err),
    .depth_o  (stk_depth),
    .full_o   (stk_full),
    .empty_o  (stk_empty),
    .ovf_o    (stk_ovf),
    .unf_o    (stk_unf)
  );

  assign alu_gnt  = alu_gnt_q;
  assign mem_gnt  = mem_gnt_q;
  assign call_gnt = call_gnt_q;
  assign ret_gnt  = ret_gnt_q;
  assign regwrite = regwrite_q;
  assign ws       = ws_q;
  assign wd       = wd_q;
  assign push     = push_q;
  assign pop      = pop_q;
  assign stack_pc = stack_pc_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed scoreboard bench for regfile_port_arbiter: expected output snapshots are
// queued as each stimulus step is driven and compared after the following edge.
module tb_regfile_port_arbiter;

  localparam logic [3:0] G_NONE = 4'b0000;
  localparam logic [3:0] G_ALU  = 4'b0001;
  localparam logic [3:0] G_MEM  = 4'b0010;
  localparam logic [3:0] G_CALL = 4'b0100;
  localparam logic [3:0] G_RET  = 4'b1000;

  typedef struct packed {
    logic [3:0]  gnt;
    logic        rw;
    logic [2:0]  ws;
    logic [31:0] wd;
    logic        push;
    logic        pop;
    logic [7:0]  pc;
    logic [3:0]  depth;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic        clk, reset;
  logic        alu_req, mem_req, call_req, ret_req, clr_err;
  logic [2:0]  alu_ws, mem_ws, ws;
  logic [31:0] alu_wd, mem_wd, wd;
  logic [7:0]  call_pc, stack_pc;
  logic        alu_gnt, mem_gnt, call_gnt, ret_gnt;
  logic        regwrite, push, pop;
  logic [3:0]  stk_depth;
  logic        stk_full, stk_empty, stk_ovf, stk_unf;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  regfile_port_arbiter #(.STACK_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .alu_req(alu_req), .alu_ws(alu_ws), .alu_wd(alu_wd),
    .mem_req(mem_req), .mem_ws(mem_ws), .mem_wd(mem_wd),
    .call_req(call_req), .call_pc(call_pc),
    .ret_req(ret_req), .clr_err(clr_err),
    .alu_gnt(alu_gnt), .mem_gnt(mem_gnt), .call_gnt(call_gnt), .ret_gnt(ret_gnt),
    .regwrite(regwrite), .ws(ws), .wd(wd),
    .push(push), .pop(pop), .stack_pc(stack_pc),
    .stk_depth(stk_depth), .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic sb_push(input logic [3:0] g, input logic rw, input logic [2:0] w_s,
                         input logic [31:0] w_d, input logic ps, input logic pp,
                         input logic [7:0] pc, input logic [3:0] d,
                         input logic ovf, input logic unf);
    exp_t e;
    e = '{gnt: g, rw: rw, ws: w_s, wd: w_d, push: ps, pop: pp,
          pc: pc, depth: d, ovf: ovf, unf: unf};
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      cmp("gnt", {28'd0, ret_gnt, call_gnt, mem_gnt, alu_gnt}, {28'd0, e.gnt});
      cmp("regwrite", {31'd0, regwrite}, {31'd0, e.rw});
      cmp("ws", {29'd0, ws}, {29'd0, e.ws});
      cmp("wd", wd, e.wd);
      cmp("push", {31'd0, push}, {31'd0, e.push});
      cmp("pop", {31'd0, pop}, {31'd0, e.pop});
      cmp("stack_pc", {24'd0, stack_pc}, {24'd0, e.pc});
      cmp("stk_depth", {28'd0, stk_depth}, {28'd0, e.depth});
      cmp("stk_full", {31'd0, stk_full}, {31'd0, (e.depth == 4'd8)});
      cmp("stk_empty", {31'd0, stk_empty}, {31'd0, (e.depth == 4'd0)});
      cmp("stk_ovf", {31'd0, stk_ovf}, {31'd0, e.ovf});
      cmp("stk_unf", {31'd0, stk_unf}, {31'd0, e.unf});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    reset = 1'b1;
    alu_req = 0; mem_req = 0; call_req = 0; ret_req = 0; clr_err = 0;
    alu_ws = '0; alu_wd = '0; mem_ws = '0; mem_wd = '0; call_pc = '0;
    #12;
    sb_push(G_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check();
    @(negedge clk);
    reset = 1'b0;

    // Simultaneous writebacks after reset: ALU first, then MEM.
    alu_req = 1; alu_ws = 3'd2; alu_wd = 32'd25;
    mem_req = 1; mem_ws = 3'd3; mem_wd = 32'd7;
    sb_push(G_ALU, 1, 2, 25, 0, 0, 0, 0, 0, 0); tick();
    alu_req = 0;
    sb_push(G_MEM, 1, 3, 7, 0, 0, 0, 0, 0, 0); tick();
    mem_req = 0;
    sb_push(G_NONE, 0, 3, 7, 0, 0, 0, 0, 0, 0); tick();

    // Call beats pending ALU writeback; ALU issued the cycle after.
    call_req = 1; call_pc = 8'd35;
    alu_req = 1; alu_ws = 3'd5; alu_wd = 32'd100;
    sb_push(G_CALL, 0, 3, 7, 1, 0, 35, 1, 0, 0); tick();
    call_req = 0;
    sb_push(G_ALU, 1, 5, 100, 0, 0, 35, 1, 0, 0); tick();
    alu_req = 0;

    // Held ret: pop, one ineligible cycle, then underflow at depth 0; clr_err clears.
    ret_req = 1;
    sb_push(G_RET, 0, 5, 100, 0, 1, 35, 0, 0, 0); tick();
    sb_push(G_NONE, 0, 5, 100, 0, 0, 35, 0, 0, 0); tick();
    sb_push(G_RET, 0, 5, 100, 0, 0, 35, 0, 0, 1); tick();
    ret_req = 0; clr_err = 1;
    sb_push(G_NONE, 0, 5, 100, 0, 0, 35, 0, 0, 0); tick();
    clr_err = 0;

    // Nine calls: eight pushes fill the stack, the ninth overflows.
    for (int i = 0; i < 9; i++) begin
      call_req = 1; call_pc = 8'(10 + i);
      if (i < 8) sb_push(G_CALL, 0, 5, 100, 1, 0, 8'(10 + i), 4'(i + 1), 0, 0);
      else       sb_push(G_CALL, 0, 5, 100, 0, 0, 8'd17, 4'd8, 1, 0);
      tick();
      call_req = 0;
      if (i < 8) sb_push(G_NONE, 0, 5, 100, 0, 0, 8'(10 + i), 4'(i + 1), 0, 0);
      else       sb_push(G_NONE, 0, 5, 100, 0, 0, 8'd17, 4'd8, 1, 0);
      tick();
    end

    // Overflow on the same edge as clr_err keeps the flag; next clear drops it.
    call_req = 1; call_pc = 8'd99; clr_err = 1;
    sb_push(G_CALL, 0, 5, 100, 0, 0, 17, 8, 1, 0); tick();
    call_req = 0;
    sb_push(G_NONE, 0, 5, 100, 0, 0, 17, 8, 0, 0); tick();
    clr_err = 0;

    // Both writebacks held: last writeback was ALU, so MEM leads the alternation.
    alu_req = 1; alu_ws = 3'd1; alu_wd = 32'h11;
    mem_req = 1; mem_ws = 3'd4; mem_wd = 32'h44;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) sb_push(G_MEM, 1, 4, 32'h44, 0, 0, 17, 8, 0, 0);
      else            sb_push(G_ALU, 1, 1, 32'h11, 0, 0, 17, 8, 0, 0);
      tick();
    end
    mem_req = 0;

    // Priority ladder: ret, then call, then ALU.
    ret_req = 1; call_req = 1; call_pc = 8'd77;
    alu_req = 1; alu_ws = 3'd6; alu_wd = 32'hdead_beef;
    sb_push(G_RET, 0, 1, 32'h11, 0, 1, 17, 7, 0, 0); tick();
    ret_req = 0;
    sb_push(G_CALL, 0, 1, 32'h11, 1, 0, 77, 8, 0, 0); tick();
    call_req = 0;
    sb_push(G_ALU, 1, 6, 32'hdead_beef, 0, 0, 77, 8, 0, 0); tick();
    alu_req = 0;

    // Clear everything, build depth 3, then reset during the fourth push.
    reset = 1; #1;
    sb_push(G_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0); check();
    #2 reset = 0;
    for (int i = 0; i < 3; i++) begin
      call_req = 1; call_pc = 8'(50 + i);
      sb_push(G_CALL, 0, 0, 0, 1, 0, 8'(50 + i), 4'(i + 1), 0, 0); tick();
      call_req = 0;
      sb_push(G_NONE, 0, 0, 0, 0, 0, 8'(50 + i), 4'(i + 1), 0, 0); tick();
    end
    call_req = 1; call_pc = 8'd53;
    alu_req = 1; alu_ws = 3'd7; alu_wd = 32'd1;
    mem_req = 1; mem_ws = 3'd0; mem_wd = 32'd2;
    sb_push(G_CALL, 0, 0, 0, 1, 0, 53, 4, 0, 0); tick();
    call_req = 0;
    reset = 1; #1;
    sb_push(G_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0); check();
    @(negedge clk);
    reset = 0;

    // Pending writebacks re-arbitrate after reset with ALU first again.
    sb_push(G_ALU, 1, 7, 1, 0, 0, 0, 0, 0, 0); tick();
    alu_req = 0;
    sb_push(G_MEM, 1, 0, 2, 0, 0, 0, 0, 0, 0); tick();
    mem_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
